// File: rtl/alu_seq_ctrl_if.sv
// Request/result handshake bundle between a requester and the ALU sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_A;
  logic [N-1:0] in_B;
  logic [3:0]   in_func;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;

  modport master (
    output in_valid, in_A, in_B, in_func, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_A, in_B, in_func, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of a combinational ALU; iterates 1-bit shifts into variable shifts.
// Optional cycle counter port cyc_cnt enabled by defining ALU_SEQ_CYCCNT_EN.
module alu_seq_ctrl #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic         busy,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [3:0]   alu_func,
  input  logic [N-1:0] alu_RES
`ifdef ALU_SEQ_CYCCNT_EN
  ,
  output logic [15:0]  cyc_cnt
`endif
);

  localparam int unsigned SHW = $clog2(N);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [N-1:0]   alu_a_q, alu_a_d;
  logic [N-1:0]   alu_b_q, alu_b_d;
  logic [3:0]     alu_func_q, alu_func_d;
  logic [N-1:0]   result_q, result_d;
  logic           out_valid_q, out_valid_d;
  logic           accept;
  logic           is_shift;
  logic [SHW-1:0] in_amt;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign in_amt   = bus.in_B[SHW-1:0];
  assign is_shift = (bus.in_func == 4'd7) || (bus.in_func == 4'd8) || (bus.in_func == 4'd9);

  // alu_a_q doubles as the shift accumulator while in SHIFT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_d      = in_amt;
          alu_a_d    = bus.in_A;
          alu_func_d = bus.in_func;
          if (is_shift && (in_amt != '0)) begin
            state_d = SHIFT;
            alu_b_d = N'(1);
          end else begin
            state_d = EXEC;
            alu_b_d = bus.in_B;
          end
        end
      end
      EXEC: begin
        result_d    = alu_RES;
        out_valid_d = 1'b1;
        state_d     = DONE;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_func_d  = '0;
      end
      SHIFT: begin
        alu_a_d = alu_RES;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d    = alu_RES;
          out_valid_d = 1'b1;
          state_d     = DONE;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_func_d  = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign busy           = (state_q != IDLE);
  assign alu_A          = alu_a_q;
  assign alu_B          = alu_b_q;
  assign alu_func       = alu_func_q;

`ifdef ALU_SEQ_CYCCNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Saturating count of cycles spent in EXEC/SHIFT for the current op.
  always_comb begin
    cyc_d = cyc_q;
    if (accept) begin
      cyc_d = '0;
    end else if (((state_q == EXEC) || (state_q == SHIFT)) && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc_cnt = cyc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the attached ALU.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] alu_A, alu_B, alu_RES;
  logic [3:0]  alu_func;
  int          checks;
  int          errors;
`ifdef ALU_SEQ_CYCCNT_EN
  logic [15:0] cyc_cnt;
`endif

  alu_seq_ctrl_if #(.N(32)) bus ();

  alu_seq_ctrl #(.N(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_func (alu_func),
    .alu_RES  (alu_RES)
`ifdef ALU_SEQ_CYCCNT_EN
    ,
    .cyc_cnt  (cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU reference: shift ops move by B[0] bits.
  always_comb begin
    case (alu_func)
      4'd0:    alu_RES = alu_A + alu_B;
      4'd1:    alu_RES = alu_A - alu_B;
      4'd7:    alu_RES = alu_A << alu_B[0];
      4'd8:    alu_RES = alu_A >> alu_B[0];
      4'd9:    alu_RES = 32'($signed(alu_A) >>> alu_B[0]);
      4'd15:   alu_RES = 32'($countones(alu_A ^ alu_B));
      default: alu_RES = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] func, input logic [31:0] exp_res,
                        input int exp_lat, input bit chk_res);
    int  lat;
    bit  shift_path;
    shift_path = (func inside {4'd7, 4'd8, 4'd9}) && (b[4:0] != 5'd0);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_A     = a;
    bus.in_B     = b;
    bus.in_func  = func;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_alu_B"}, alu_B, shift_path ? 32'd1 : b);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (chk_res) check({tag, "_result"}, bus.out_result, exp_res);
    check({tag, "_alu_idle"}, alu_A | alu_B | 32'(alu_func), 32'd0);
`ifdef ALU_SEQ_CYCCNT_EN
    check({tag, "_cyc_cnt"}, 32'(cyc_cnt), 32'(exp_lat));
`endif
    @(posedge clk);
    #1;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_A      = '0;
    bus.in_B      = '0;
    bus.in_func   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_result", bus.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 32'h5, 32'h3, 4'd0, 32'h8, 1, 1'b1);
    run_op("sra4", 32'h8000_0000, 32'd4, 4'd9, 32'hF800_0000, 4, 1'b1);
    run_op("sll5", 32'h1, 32'h25, 4'd7, 32'h20, 5, 1'b1);
    run_op("srl0", 32'hDEAD_BEEF, 32'd0, 4'd8, 32'hDEAD_BEEF, 1, 1'b1);
    run_op("srl3", 32'hF000_0000, 32'd3, 4'd8, 32'h1E00_0000, 3, 1'b1);

    // Abort a long shift with an asynchronous reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_A     = 32'h1;
    bus.in_B     = 32'd20;
    bus.in_func  = 4'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", bus.out_result, 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_alu_A", alu_A, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_abort", 32'd100, 32'd23, 4'd0, 32'd123, 1, 1'b1);

    // Stall in DONE while a second request waits.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_A     = 32'd3;
    bus.in_B     = 32'd5;
    bus.in_func  = 4'd1;
    @(posedge clk);
    #1;
    bus.in_A    = 32'd5;
    bus.in_B    = 32'd3;
    bus.in_func = 4'd0;
    @(posedge clk);
    #1;
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("stall_result", bus.out_result, 32'hFFFF_FFFE);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("stall_still_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_idle", 32'(bus.in_ready), 32'd1);
    check("stall_release_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("queued_accept_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("queued_valid", 32'(bus.out_valid), 32'd1);
    check("queued_result", bus.out_result, 32'd8);
    @(posedge clk);
    #1;
    check("queued_idle", 32'(bus.in_ready), 32'd1);

`ifdef ALU_SEQ_CYCCNT_EN
    run_op("sll31", 32'h1, 32'd31, 4'd7, 32'h8000_0000, 31, 1'b1);
    run_op("hamm", 32'hFF, 32'h0F, 4'd15, 32'd4, 1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
